// File: rtl/lpif_online_sequencer_pkg.sv
// Shared definitions for the LPIF online sequencer: state encoding and
// debug status layout.
package lpif_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DLY_Y   = 4'd1,
        ST_DLY_Z   = 4'd2,
        ST_TX_UP   = 4'd3,
        ST_LINK_UP = 4'd4
    } seq_state_e;

    // Bit offsets of the fields inside seq_debug_status
    localparam int unsigned STAT_STATE_LSB = 0;
    localparam int unsigned STAT_DROP_LSB  = 8;
    localparam int unsigned STAT_CNT_LSB   = 16;

    // Assemble {counter, drop_count, 4'h0, state}
    function automatic logic [31:0] pack_status(input logic [15:0] cnt,
                                                input logic [7:0]  drops,
                                                input logic [3:0]  st);
        logic [31:0] s;
        s = '0;
        s[STAT_CNT_LSB   +: 16] = cnt;
        s[STAT_DROP_LSB  +: 8]  = drops;
        s[STAT_STATE_LSB +: 4]  = st;
        return s;
    endfunction

endpackage

// File: rtl/lpif_online_sequencer_if.sv
// Link handshake bundle between the LPIF adapter side and the sequencer.
interface lpif_online_sequencer_if;
    logic       tx_online;
    logic       rx_online;
    logic [3:0] dstrm_valid_in;
    logic       tx_online_delay;
    logic       rx_online_delay;
    logic       link_up;
    logic [3:0] dstrm_valid_out;

    // Adapter / environment side
    modport master (
        output tx_online, rx_online, dstrm_valid_in,
        input  tx_online_delay, rx_online_delay, link_up, dstrm_valid_out
    );

    // Sequencer side
    modport slave (
        input  tx_online, rx_online, dstrm_valid_in,
        output tx_online_delay, rx_online_delay, link_up, dstrm_valid_out
    );
endinterface

// File: rtl/lpif_online_sequencer_dly_cnt.sv
// 16-bit loadable down-counter with a zero flag for the dwell delays.
module lpif_seq_dly_cnt (
    input  logic        clk_wr,
    input  logic        rst_wr_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        dec,
    output logic [15:0] count,
    output logic        zero
);

    // Load has priority over decrement; reset clears the count
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec)
            count <= count - 16'd1;
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/lpif_online_sequencer.sv
// LPIF online sequencer: brings TX up after Y/Z dwell, then waits for RX
// to be stable for X cycles before declaring link_up.
module lpif_online_sequencer
    import lpif_seq_pkg::*;
(
    input  logic                    clk_wr,
    input  logic                    rst_wr_n,
    lpif_online_sequencer_if.slave  lnk,
    input  logic [15:0]             delay_x_value,
    input  logic [15:0]             delay_y_value,
    input  logic [15:0]             delay_z_value,
    input  logic [3:0]              tx_mrk_userbit,
    input  logic                    tx_stb_userbit,
    output logic [3:0]              tx_auto_mrk_userbit,
    output logic                    tx_auto_stb_userbit,
    output logic [31:0]             seq_debug_status
);

    seq_state_e  state, state_nxt;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [15:0] cnt_load_value, cnt;
    logic [7:0]  drop_count;
    logic        tx_online_q, link_up_q;

    lpif_seq_dly_cnt u_dly_cnt (
        .clk_wr     (clk_wr),
        .rst_wr_n   (rst_wr_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    // State register
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and counter control; tx_online loss overrides everything
    always_comb begin
        state_nxt      = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        if (!lnk.tx_online) begin
            state_nxt = ST_IDLE;
            cnt_load  = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt      = ST_DLY_Y;
                    cnt_load       = 1'b1;
                    cnt_load_value = delay_y_value;
                end
                ST_DLY_Y: begin
                    if (cnt_zero) begin
                        state_nxt      = ST_DLY_Z;
                        cnt_load       = 1'b1;
                        cnt_load_value = delay_z_value;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DLY_Z: begin
                    if (cnt_zero) begin
                        state_nxt      = ST_TX_UP;
                        cnt_load       = 1'b1;
                        cnt_load_value = delay_x_value;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_TX_UP: begin
                    if (!lnk.rx_online) begin
                        cnt_load       = 1'b1;
                        cnt_load_value = delay_x_value;
                    end else if (cnt_zero) begin
                        state_nxt = ST_LINK_UP;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (!lnk.rx_online) begin
                        state_nxt      = ST_TX_UP;
                        cnt_load       = 1'b1;
                        cnt_load_value = delay_x_value;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_load  = 1'b1;
                end
            endcase
        end
    end

    // Output flops decoded from the next state so they line up with state
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            tx_online_q         <= 1'b0;
            link_up_q           <= 1'b0;
            tx_auto_mrk_userbit <= '0;
            tx_auto_stb_userbit <= 1'b0;
        end else begin
            tx_online_q <= (state_nxt == ST_TX_UP) || (state_nxt == ST_LINK_UP);
            link_up_q   <= (state_nxt == ST_LINK_UP);
            if ((state_nxt == ST_DLY_Z) || (state_nxt == ST_TX_UP) ||
                (state_nxt == ST_LINK_UP)) begin
                tx_auto_mrk_userbit <= tx_mrk_userbit;
                tx_auto_stb_userbit <= tx_stb_userbit;
            end else begin
                tx_auto_mrk_userbit <= '0;
                tx_auto_stb_userbit <= 1'b0;
            end
        end
    end

    // Saturating count of exits from LINK_UP
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n)
            drop_count <= '0;
        else if ((state == ST_LINK_UP) && (state_nxt != ST_LINK_UP) &&
                 (drop_count != 8'hFF))
            drop_count <= drop_count + 8'd1;
    end

    assign lnk.tx_online_delay = tx_online_q;
    assign lnk.rx_online_delay = link_up_q;
    assign lnk.link_up         = link_up_q;
    assign lnk.dstrm_valid_out = lnk.dstrm_valid_in & {4{link_up_q}};
    assign seq_debug_status    = pack_status(cnt, drop_count, state);

endmodule

// File: doc/lpif_online_sequencer.md
LPIF_ONLINE_SEQUENCER -- requirements
Module: lpif_online_sequencer

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk_wr  input  1  single clock; every flop SHALL be clocked on its rising edge.
REQ-003 rst_wr_n  input  1  synchronous active-low reset.
REQ-004 tx_online  input  1  local TX channel ready (aligned, AIB up).
REQ-005 rx_online  input  1  local RX channel ready (word/channel aligned).
REQ-006 delay_x_value, delay_y_value, delay_z_value  input  16 each  RX-online, pre-marker and marker/strobe dwell counts.
REQ-007 tx_mrk_userbit  input  4 and tx_stb_userbit  input  1  configured marker/strobe bits.
REQ-008 dstrm_valid_in  input  4  per-quarter valid from the LPIF adapter.
REQ-009 tx_online_delay  output  1  drives the PHY concat tx_online.
REQ-010 rx_online_delay  output  1  qualified RX online.
REQ-011 tx_auto_mrk_userbit  output  4 and tx_auto_stb_userbit  output  1  gated marker/strobe bits.
REQ-012 dstrm_valid_out  output  4  valid gated by link_up.
REQ-013 link_up  output  1  TX and RX both sequenced up.
REQ-014 seq_debug_status  output  32  state/counter snapshot.

Function
REQ-015 The FSM SHALL have states IDLE(0), DLY_Y(1), DLY_Z(2), TX_UP(3) and LINK_UP(4), held in a 4-bit register.
REQ-016 IDLE->DLY_Y when tx_online=1; the 16-bit counter SHALL load delay_y_value on entry.
REQ-017 In DLY_Y/DLY_Z the counter SHALL decrement each cycle; the state SHALL exit on the cycle the counter equals 0, giving exactly delay+1 cycles per state (delay 0 = 1 cycle).
REQ-018 DLY_Y->DLY_Z SHALL load delay_z_value; DLY_Z->TX_UP SHALL load delay_x_value.
REQ-019 Delay inputs SHALL be sampled only at load; changes mid-count SHALL have no effect.
REQ-020 In TX_UP the counter SHALL decrement only while rx_online=1, reload delay_x_value when rx_online=0, and enter LINK_UP on the cycle it is 0 with rx_online=1.
REQ-021 LINK_UP->TX_UP (counter reloaded with delay_x_value) SHALL occur when rx_online=0.
REQ-022 Any state->IDLE SHALL occur when tx_online=0; this has priority over every other transition, including simultaneous counter expiry and an rx_online drop.
REQ-023 All outputs SHALL be registered: each reflects the state register, with no combinational path from inputs (except REQ-027).
REQ-024 tx_auto_mrk_userbit/tx_auto_stb_userbit SHALL equal the configured bits in DLY_Z, TX_UP and LINK_UP (persistent), and 0 otherwise.
REQ-025 tx_online_delay SHALL be 1 in TX_UP and LINK_UP.
REQ-026 rx_online_delay and link_up SHALL be 1 in LINK_UP only.
REQ-027 dstrm_valid_out SHALL equal dstrm_valid_in AND {4{link_up}} (combinational on the registered link_up).
REQ-028 An 8-bit drop_count SHALL increment on each exit from LINK_UP and saturate at 0xFF.
REQ-029 seq_debug_status SHALL be {counter[15:0], drop_count[7:0], 4'h0, state[3:0]}.

Reset
REQ-030 While rst_wr_n=0 at a clock edge: state=IDLE, counter=0, drop_count=0, and all outputs 0.
REQ-031 Reset asserted mid-sequence SHALL abort to IDLE on the next edge with no partial outputs.
REQ-032 After release, sequencing SHALL restart from IDLE.

Structure
REQ-033 The state enum (4-bit encoding) and the status field offsets SHALL live in a shared package, lpif_seq_pkg.
REQ-034 One sub-module, lpif_seq_dly_cnt (16-bit loadable down-counter with a zero flag), is natural; everything else SHALL be flat.
REQ-035 Target size is 120-250 lines of RTL.

Verification
REQ-036 y=2, z=3, x=1; tx_online and rx_online rise together -> tx_online_delay rises 7 cycles after the IDLE exit, and link_up 2 cycles after that.
REQ-037 All delays 0 -> DLY_Y, DLY_Z and TX_UP each last 1 cycle; link_up is asserted 4 cycles after tx_online rises.
REQ-038 In LINK_UP, drop rx_online for 1 cycle -> link_up=0 and dstrm_valid_out=0, drop_count=1; link_up reasserts x+1 cycles after rx_online returns.
REQ-039 tx_online falls on the same cycle the DLY_Z counter hits 0 -> next state is IDLE and the marker/strobe bits are 0.
REQ-040 Force 300 LINK_UP exits -> drop_count reads 0xFF.
REQ-041 Change delay_z_value to 0xFFFF mid-DLY_Z, then assert reset mid-DLY_Y -> dwell is unchanged, and after reset all outputs are 0 and the status reads 0x00000000.
